// File: rtl/uart_tx_fifo_bridge.sv
// rtl/uart_tx_fifo_bridge.sv - byte FIFO between UART receiver and transmitter in the echo path
//
// Ports:
//   clk          system clock
//   reset        asynchronous active-low reset
//   i_wr_valid   one-cycle pulse, i_wr_data holds a received byte
//   i_wr_data    received byte
//   i_tx_done    one-cycle pulse from the transmitter, frame finished
//   o_tx_start   one-cycle pulse launching a transmitter frame
//   o_tx_data    byte being transmitted, stable from o_tx_start until i_tx_done
//   o_count      bytes held in the FIFO (the byte in flight is not counted)
//   o_empty      o_count == 0
//   o_full       o_count == DEPTH
//   o_overflow   sticky, a byte was dropped because the FIFO was full
module uart_tx_fifo_bridge #(
    parameter int DEPTH  = 16,
    parameter int ADDR_W = 4
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              i_wr_valid,
    input  logic [7:0]        i_wr_data,
    input  logic              i_tx_done,
    output logic              o_tx_start,
    output logic [7:0]        o_tx_data,
    output logic [ADDR_W:0]   o_count,
    output logic              o_empty,
    output logic              o_full,
    output logic              o_overflow
);

    typedef enum logic [1:0] {
        IDLE,
        START,
        BUSY,
        GAP
    } state_t;

    localparam logic [ADDR_W:0] COUNT_FULL = (ADDR_W + 1)'(DEPTH);

    state_t            state;
    logic [7:0]        mem [DEPTH];
    logic [ADDR_W-1:0] wr_ptr;
    logic [ADDR_W-1:0] rd_ptr;
    logic              pop;
    logic              push;

    assign o_empty = (o_count == '0);
    assign o_full  = (o_count == COUNT_FULL);

    // A pop frees a slot on the same edge, so a full FIFO still accepts a byte
    // when the FSM launches a frame on that edge.
    assign pop  = (state == IDLE) && !o_empty;
    assign push = i_wr_valid && (!o_full || pop);

    // Storage carries no reset; stale contents are unreachable once the
    // pointers and count are cleared.
    always_ff @(posedge clk) begin
        if (push) begin
            mem[wr_ptr] <= i_wr_data;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state      <= IDLE;
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            o_count    <= '0;
            o_tx_start <= 1'b0;
            o_tx_data  <= 8'h00;
            o_overflow <= 1'b0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (i_wr_valid && !push) begin
                o_overflow <= 1'b1;
            end

            case ({push, pop})
                2'b10:   o_count <= o_count + 1'b1;
                2'b01:   o_count <= o_count - 1'b1;
                default: o_count <= o_count;
            endcase

            case (state)
                IDLE: begin
                    if (pop) begin
                        // On a full-FIFO push+pop, wr_ptr == rd_ptr; the read
                        // returns the old byte because the write lands after this edge.
                        o_tx_data  <= mem[rd_ptr];
                        rd_ptr     <= rd_ptr + 1'b1;
                        o_tx_start <= 1'b1;
                        state      <= START;
                    end
                end
                START: begin
                    // i_tx_done cannot belong to this frame yet, so it is ignored here.
                    o_tx_start <= 1'b0;
                    state      <= BUSY;
                end
                BUSY: begin
                    if (i_tx_done) begin
                        state <= GAP;
                    end
                end
                GAP: begin
                    // Keeps two cycles between i_tx_done and the next o_tx_start.
                    state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule
